fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Program-counter and instruction-fetch stage that sits directly upstream of the combinational instruction memory. It drives the 8-bit byte address, captures the returned 32-bit word together with its PC into a small fetch queue, and presents {pc, instr} to decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue and reload the PC.

Parameters:
ADDR_W, 8, byte-address width of PC and instruction memory
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset; must be word-aligned
DEPTH, 2, fetch-queue entries; power of two, at least 2

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  fetch enable; 0 freezes PC, queue still drains
imem_addr  out  ADDR_W  byte address to instruction memory; equals current PC
imem_instr  in  DATA_W  instruction word returned combinationally for imem_addr
redirect_valid  in  1  execute requests PC change this cycle
redirect_pc  in  ADDR_W  target byte address; low 2 bits ignored
out_valid  out  1  queue head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  DATA_W  head instruction
out_pc  out  ADDR_W  byte address of head instruction

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled only at the rising edge of clk.
- Reset (rst_n=0 at an edge): pc<=RESET_PC, queue count<=0, read/write pointers<=0.
  - After reset: imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- imem_addr = pc, combinational from the PC register. The memory is asynchronous-read, so the word at imem_addr is valid in the same cycle.
- pop = out_valid && out_ready.
- push = run && !redirect_valid && (count<DEPTH || pop).
  - On push, {pc, imem_instr} is written at the tail and pc<=pc+4.
  - PC arithmetic is modulo 2^ADDR_W: 0xFC+4 wraps to 0x00.
- Simultaneous push and pop while full is allowed; count is unchanged.
- Push and pop in the same cycle while empty: the new entry is written and becomes visible next cycle. There is no combinational bypass from imem to out.
- Redirect has priority over all other events. On an edge with redirect_valid=1:
  - the queue is flushed (count<=0, pointers<=0);
  - pc<=redirect_pc with the low 2 bits forced to 0;
  - no push that cycle; any concurrent pop is discarded (decode must drop the current head).
- out_valid = (count!=0). out_instr and out_pc come combinationally from queue storage at the read pointer and are forced to 0 when the queue is empty.
- Latency: from an edge where push occurs, the instruction appears on out_* one cycle later. After reset release with run=1 and out_ready=1, throughput is 1 instruction per cycle.
- Backpressure: with out_ready=0, the queue fills after DEPTH pushes. PC then holds and imem_addr stays on the next unfetched address.
- run=0: PC holds and nothing is pushed. The queue continues to pop.
- Reset asserted mid-stream overrides redirect, push and pop; all queued entries are lost.

Decomposition:
- fetch_pkg holds:
  - ADDR_W, DATA_W, PC_STEP=4, RESET_PC defaults;
  - a fetch_entry_t struct {pc, instr}.
- Sub-module fetch_queue: DEPTH-entry synchronous FIFO with push, pop and flush inputs, plus count/full/empty outputs. Flush has priority over push and pop.
- fetch_unit instantiates fetch_queue and owns only the PC register and the push/redirect logic.

Test Plan:
1. Streaming. Bench imem model holds word0=0x00007033, word1=0x00100093, word2=0x00200113. Release reset with run=1, out_ready=1. Required: out_valid rises 1 cycle after release; then pc/instr pairs (0x00,0x00007033), (0x04,0x00100093), (0x08,0x00200113) appear on consecutive cycles.
2. Backpressure. Hold out_ready=0 for 5 cycles. Required: count saturates at 2 and imem_addr freezes at 0x08. Then set out_ready=1: pairs 0x00 and 0x04 drain in order, followed by 0x08, with no gap or duplicate.
3. Redirect. Queue holds 0x04 and 0x08; assert redirect_valid with redirect_pc=0x4B. Required: next cycle out_valid=0 and imem_addr=0x48; the following cycle out_pc=0x48.
4. Wrap. Redirect to 0xF8 and stream 3 instructions. Required: out_pc sequence 0xF8, 0xFC, 0x00.
5. Reset mid-operation. With a full queue, drive rst_n=0 for 1 edge. Required: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC; resumes at 0x00 after release.
6. run=0 with 2 entries queued and out_ready=1. Required: both entries drain, then out_valid=0 with the PC unchanged. Redirect during run=0 still reloads the PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage defaults and the queue entry layout.
package fetch_pkg;
   localparam int FETCH_ADDR_W   = 8;
   localparam int FETCH_DATA_W   = 32;
   localparam int PC_STEP        = 4;
   localparam int FETCH_RESET_PC = 0;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush beats push/pop.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int W     = 40
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic          push_ok, pop_ok;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // a full queue may still accept a write when the head leaves the same cycle
   assign push_ok = push && (!full || pop_ok);
   assign count   = cnt;
   assign rdata   = mem[rp];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push_ok) wp <= wp + 1'b1;
         if (pop_ok)  rp <= rp + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !flush && push_ok) mem[wp] <= wdata;
   end
endmodule

// File: rtl/fetch_unit.sv
// PC register and fetch control feeding a small queue in front of decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                DATA_W   = FETCH_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_instr,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc
);
   localparam int EW = ADDR_W + DATA_W;

   logic [ADDR_W-1:0]          pc;
   logic [EW-1:0]              q_rdata;
   logic [$clog2(DEPTH+1)-1:0] q_count;
   logic                       q_full, q_empty;
   logic                       push, pop;

   assign imem_addr = pc;
   assign out_valid = (q_count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = run && !redirect_valid && (!q_full || pop);
   assign out_pc    = q_empty ? '0 : q_rdata[EW-1 -: ADDR_W];
   assign out_instr = q_empty ? '0 : q_rdata[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n)              pc <= RESET_PC;
      else if (redirect_valid) pc <= redirect_pc & ~ADDR_W'(3);
      else if (push)           pc <= pc + ADDR_W'(PC_STEP);
   end

   fetch_queue #(.DEPTH(DEPTH), .W(EW)) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata ({pc, imem_instr}),
      .rdata (q_rdata),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed checks of the fetch stage against a behavioural instruction memory.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, run, redirect_valid, out_ready, out_valid;
   logic [7:0]  imem_addr, redirect_pc, out_pc;
   logic [31:0] imem_instr, out_instr;
   int          checks = 0, failures = 0;
   fetch_entry_t exp;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr),
      .imem_instr(imem_instr), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   function automatic logic [31:0] imem_word(input logic [7:0] a);
      case (a[7:2])
         6'd0:    return 32'h0000_7033;
         6'd1:    return 32'h0010_0093;
         6'd2:    return 32'h0020_0113;
         default: return 32'hC0DE_0000 | {24'h0, a};
      endcase
   endfunction

   always_comb imem_instr = imem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [7:0] pc, input logic [31:0] ins);
      exp.pc = pc;
      exp.instr = ins;
      chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
      chk({tag, "_pc"}, {24'h0, out_pc}, {24'h0, exp.pc});
      chk({tag, "_instr"}, out_instr, exp.instr);
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
      chk({tag, "_pc"}, {24'h0, out_pc}, 32'h0);
      chk({tag, "_instr"}, out_instr, 32'h0);
   endtask

   initial begin
      rst_n = 0; run = 0; out_ready = 0; redirect_valid = 0; redirect_pc = 8'h00;
      tick(); tick();
      chk_empty("reset");
      chk("reset_addr", {24'h0, imem_addr}, 32'h00);

      // 1: streaming
      rst_n = 1; run = 1; out_ready = 1;
      tick(); chk_head("s0", 8'h00, 32'h0000_7033);
      chk("s0_addr", {24'h0, imem_addr}, 32'h04);
      tick(); chk_head("s1", 8'h04, 32'h0010_0093);
      tick(); chk_head("s2", 8'h08, 32'h0020_0113);

      // 2: backpressure from a fresh start
      rst_n = 0; tick();
      rst_n = 1; out_ready = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("bp_addr", {24'h0, imem_addr}, 32'h08);
      chk_head("bp_head", 8'h00, 32'h0000_7033);
      out_ready = 1;
      tick(); chk_head("bp_d1", 8'h04, 32'h0010_0093);
      tick(); chk_head("bp_d2", 8'h08, 32'h0020_0113);

      // 3: redirect with queue holding 0x04/0x08
      rst_n = 0; tick();
      rst_n = 1; out_ready = 0;
      tick(); tick();
      out_ready = 1; tick();
      out_ready = 0;
      chk_head("rd_pre", 8'h04, 32'h0010_0093);
      redirect_valid = 1; redirect_pc = 8'h4B;
      tick();
      redirect_valid = 0; out_ready = 1;
      chk_empty("rd_flush");
      chk("rd_addr", {24'h0, imem_addr}, 32'h48);
      tick(); chk_head("rd_tgt", 8'h48, 32'hC0DE_0048);

      // 4: PC wrap
      redirect_valid = 1; redirect_pc = 8'hF8;
      tick();
      redirect_valid = 0;
      tick(); chk_head("wr0", 8'hF8, 32'hC0DE_00F8);
      tick(); chk_head("wr1", 8'hFC, 32'hC0DE_00FC);
      chk("wr_addr", {24'h0, imem_addr}, 32'h00);
      tick(); chk_head("wr2", 8'h00, 32'h0000_7033);

      // 5: reset with a full queue
      out_ready = 0;
      tick(); chk("full_addr", {24'h0, imem_addr}, 32'h08);
      rst_n = 0; tick();
      chk_empty("mrst");
      chk("mrst_addr", {24'h0, imem_addr}, 32'h00);
      rst_n = 1; out_ready = 1;
      tick(); chk_head("mrst_res", 8'h00, 32'h0000_7033);

      // 6: run=0 drains without fetching
      out_ready = 0; tick();
      run = 0; out_ready = 1;
      tick(); chk_head("run0_d1", 8'h04, 32'h0010_0093);
      tick(); chk_empty("run0_empty");
      chk("run0_addr", {24'h0, imem_addr}, 32'h08);
      tick(); chk("run0_hold", {24'h0, imem_addr}, 32'h08);
      redirect_valid = 1; redirect_pc = 8'h22;
      tick(); redirect_valid = 0;
      chk("run0_redir", {24'h0, imem_addr}, 32'h20);
      tick(); chk("run0_redir_hold", {24'h0, imem_addr}, 32'h20);
      chk("run0_novalid", {31'h0, out_valid}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
